// File: rtl/stack_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg
// Shared constants and types for the LIFO stack and its command front-end.
//   DATA_W   : stack data width
//   DEPTH    : stack capacity in entries
//   DEPTH_W  : width of a depth count holding 0..DEPTH
//   OP_PUSH / OP_POP : command opcodes
//   STK_LAT  : clock edges from a push/pop strobe until the stack reports
//   state_t  : front-end FSM state encoding
// ---------------------------------------------------------------------------
package stack_pkg;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int DEPTH_W = $clog2(DEPTH + 1);

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  // The stack registers the strobe on the first edge and updates its state,
  // data_out and error on the second edge.
  localparam int STK_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/stack_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// stack_cmd_ctrl_if
// Command and response channels of the stack command front-end.
//   cmd_valid/cmd_ready : command handshake; cmd_op 0=push 1=pop,
//                         cmd_data is the push payload
//   rsp_valid/rsp_ready : response handshake; rsp_data popped value,
//                         rsp_error stack over/underflow, rsp_depth depth
//                         after the command
// Modports: master = command source / response sink, slave = controller.
// ---------------------------------------------------------------------------
interface stack_cmd_ctrl_if #(
  parameter int DATA_W  = stack_pkg::DATA_W,
  parameter int DEPTH_W = stack_pkg::DEPTH_W
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_op;
  logic [DATA_W-1:0]  cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_W-1:0]  rsp_data;
  logic               rsp_error;
  logic [DEPTH_W-1:0] rsp_depth;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error, rsp_depth
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_error, rsp_depth
  );

endinterface

// File: rtl/stack_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// stack_cmd_ctrl
// Command front-end for the LIFO stack. Accepts one push/pop command at a
// time, pulses the stack's push/pop for one cycle, waits out the stack
// latency, then returns popped data, the stack error flag and a shadow depth
// count on the response channel. All outputs are registered.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   bus            : command/response channels (slave modport)
//   stk_push/pop   : one-cycle strobes to the stack
//   stk_data_in    : push payload to the stack
//   stk_data_out   : popped value from the stack
//   stk_error      : stack over/underflow flag (valid only in CAPTURE)
//   empty, full    : shadow depth == 0 / == DEPTH
// ---------------------------------------------------------------------------
module stack_cmd_ctrl #(
  parameter int DATA_W  = stack_pkg::DATA_W,
  parameter int DEPTH   = stack_pkg::DEPTH,
  parameter int DEPTH_W = stack_pkg::DEPTH_W
) (
  input  logic              clk,
  input  logic              reset,
  stack_cmd_ctrl_if.slave   bus,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_data_in,
  input  logic [DATA_W-1:0] stk_data_out,
  input  logic              stk_error,
  output logic              empty,
  output logic              full
);

  import stack_pkg::*;

  // WAIT lasts STK_LAT-1 cycles so that CAPTURE lines up with the cycle in
  // which the stack presents its result (STK_LAT >= 2).
  localparam logic [3:0] WAIT_CNT_INIT = 4'(STK_LAT - 2);

  state_t             state_q;
  logic               op_q;
  logic [3:0]         wait_cnt_q;
  logic               cmd_ready_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_error_q;
  logic               stk_push_q;
  logic               stk_pop_q;
  logic [DATA_W-1:0]  stk_data_in_q;
  logic [DEPTH_W-1:0] depth_q;
  logic               empty_q;
  logic               full_q;

  logic [DEPTH_W-1:0] depth_d;
  logic [DATA_W-1:0]  rsp_data_d;

  // Outcome of the in-flight command, meaningful only while in CAPTURE.
  // An errored command leaves the depth alone and returns zero data.
  always_comb begin
    depth_d    = depth_q;
    rsp_data_d = '0;
    if (!stk_error) begin
      if (op_q == OP_PUSH) begin
        depth_d = depth_q + DEPTH_W'(1);
      end else begin
        depth_d    = depth_q - DEPTH_W'(1);
        rsp_data_d = stk_data_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_PUSH;
      wait_cnt_q    <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      stk_push_q    <= 1'b0;
      stk_pop_q     <= 1'b0;
      stk_data_in_q <= '0;
      depth_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Strobes are raised on the accept edge so they are high for
          // exactly the ISSUE cycle. No local suppression on full/empty.
          if (bus.cmd_valid) begin
            op_q          <= bus.cmd_op;
            stk_data_in_q <= bus.cmd_data;
            stk_push_q    <= (bus.cmd_op == OP_PUSH);
            stk_pop_q     <= (bus.cmd_op == OP_POP);
            cmd_ready_q   <= 1'b0;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          stk_push_q <= 1'b0;
          stk_pop_q  <= 1'b0;
          wait_cnt_q <= WAIT_CNT_INIT;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_q == '0) begin
            state_q <= ST_CAPTURE;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        ST_CAPTURE: begin
          // The stack clears error one cycle later, so this is the only
          // cycle in which stk_error belongs to the current command.
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= rsp_data_d;
          rsp_error_q <= stk_error;
          depth_q     <= depth_d;
          empty_q     <= (depth_d == '0);
          full_q      <= (depth_d == DEPTH_W'(DEPTH));
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          stk_push_q  <= 1'b0;
          stk_pop_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_depth = depth_q;
  assign stk_push      = stk_push_q;
  assign stk_pop       = stk_pop_q;
  assign stk_data_in   = stk_data_in_q;
  assign empty         = empty_q;
  assign full          = full_q;

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_cmd_ctrl
// Drives stack_cmd_ctrl against a behavioural 16x8 LIFO stack with the
// two-edge latency, checks directed vectors with literal expectations and
// compares every cycle against a queue-based model of the stack.
// ---------------------------------------------------------------------------
module tb_stack_cmd_ctrl;

  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int DPW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stk_push, stk_pop, stk_error, empty, full;
  logic [DW-1:0] stk_data_in, stk_data_out;

  stack_cmd_ctrl_if #(.DATA_W(DW), .DEPTH_W(DPW)) bus ();

  stack_cmd_ctrl #(.DATA_W(DW), .DEPTH(DEP), .DEPTH_W(DPW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_error    (stk_error),
    .empty        (empty),
    .full         (full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stack: strobes registered on one edge, state/data/error
  // updated on the next; error is a one-cycle pulse; errored pop leaves
  // data_out stale.
  logic [DW-1:0] smem [DEP];
  int            scnt;
  logic          push_r, pop_r;
  logic [DW-1:0] din_r;
  always @(posedge clk) begin
    if (reset) begin
      push_r <= 1'b0; pop_r <= 1'b0; din_r <= '0;
      scnt <= 0; stk_data_out <= '0; stk_error <= 1'b0;
    end else begin
      push_r    <= stk_push;
      pop_r     <= stk_pop;
      din_r     <= stk_data_in;
      stk_error <= 1'b0;
      if (push_r) begin
        if (scnt == DEP) stk_error <= 1'b1;
        else begin smem[scnt] <= din_r; scnt <= scnt + 1; end
      end else if (pop_r) begin
        if (scnt == 0) stk_error <= 1'b1;
        else begin stk_data_out <= smem[scnt-1]; scnt <= scnt - 1; end
      end
    end
  end

  // ---------------- model and scoreboard ----------------
  typedef struct {
    logic          op;
    logic [DW-1:0] din;
    logic [DW-1:0] data;
    logic          err;
    int            depth;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_stk[$];
  int            model_depth = 0;
  bit            inflight = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            push_cnt = 0;
  int            pop_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      push_cnt = 0;
      pop_cnt  = 0;
    end else begin
      check("cmd_ready", 32'(bus.cmd_ready), 32'(!inflight));
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          check("m_rsp_data", 32'(bus.rsp_data), 32'(exp_q[0].data));
          check("m_rsp_error", 32'(bus.rsp_error), 32'(exp_q[0].err));
          check("m_rsp_depth", 32'(bus.rsp_depth), 32'(exp_q[0].depth));
          check("m_empty", 32'(empty), 32'(exp_q[0].depth == 0));
          check("m_full", 32'(full), 32'(exp_q[0].depth == DEP));
          if (stk_push || stk_pop) check("strobe_in_resp", 32'({stk_push, stk_pop}), 32'd0);
          if (bus.rsp_ready) begin
            check("push_pulses", 32'(push_cnt), 32'(exp_q[0].op == 1'b0));
            check("pop_pulses", 32'(pop_cnt), 32'(exp_q[0].op == 1'b1));
            model_depth = exp_q[0].depth;
            void'(exp_q.pop_front());
            inflight = 0;
            push_cnt = 0;
            pop_cnt  = 0;
          end
        end
      end else begin
        check("m_empty_idle", 32'(empty), 32'(model_depth == 0));
        check("m_full_idle", 32'(full), 32'(model_depth == DEP));
        if (stk_push) begin
          push_cnt++;
          if (exp_q.size() != 0) check("stk_data_in", 32'(stk_data_in), 32'(exp_q[0].din));
        end
        if (stk_pop) pop_cnt++;
      end
    end
  end

  // One command with literal expectations; hold > 0 keeps rsp_ready low for
  // that many cycles after the response appears.
  task automatic do_cmd(input logic op, input logic [DW-1:0] din,
                        input logic [DW-1:0] ed, input logic ee, input int edep,
                        input int hold, output int acc_cyc);
    exp_t e;
    int   lat;
    bit   acc;
    acc = 0;
    lat = 0;
    acc_cyc = -1;
    bus.rsp_ready = (hold == 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = din;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        @(posedge clk);
        acc = 1;
        break;
      end
    end
    if (!acc) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'hEE;
    e.op = op; e.din = din; e.data = '0; e.err = 1'b0;
    if (op == 1'b0) begin
      if (model_stk.size() == DEP) e.err = 1'b1;
      else model_stk.push_back(din);
    end else begin
      if (model_stk.size() == 0) e.err = 1'b1;
      else e.data = model_stk.pop_back();
    end
    e.depth = model_stk.size();
    exp_q.push_back(e);
    inflight = 1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin lat = k; break; end
    end
    check("latency", 32'(lat), 32'd3);
    if (lat == 0) return;
    $display("cmd op=%0d din=0x%02h -> rsp_data=0x%02h err=%0d depth=%0d",
             op, din, bus.rsp_data, bus.rsp_error, bus.rsp_depth);
    check("rsp_data", 32'(bus.rsp_data), 32'(ed));
    check("rsp_error", 32'(bus.rsp_error), 32'(ee));
    check("rsp_depth", 32'(bus.rsp_depth), 32'(edep));
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      check("held_valid", 32'(bus.rsp_valid), 32'd1);
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ac, prev_ac;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_rsp_depth", 32'(bus.rsp_depth), 32'd0);
    check("rst_strobes", 32'({stk_push, stk_pop}), 32'd0);
    check("rst_data_in", 32'(stk_data_in), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    @(posedge clk); #1;

    // Push 0xA5 then pop it back
    do_cmd(1'b0, 8'hA5, 8'h00, 1'b0, 1, 0, ac);
    do_cmd(1'b1, 8'h00, 8'hA5, 1'b0, 0, 0, ac);

    // Fill to 16, back-to-back at one command per 5 cycles
    prev_ac = -1;
    for (int i = 1; i <= 16; i++) begin
      do_cmd(1'b0, 8'(i), 8'h00, 1'b0, i, 0, ac);
      if (prev_ac >= 0) check("throughput", 32'(ac - prev_ac), 32'd5);
      prev_ac = ac;
    end
    @(negedge clk);
    check("full_after_16", 32'(full), 32'd1);
    check("not_empty_16", 32'(empty), 32'd0);
    @(posedge clk); #1;
    for (int i = 1; i <= 16; i++)
      do_cmd(1'b1, 8'h00, 8'(17 - i), 1'b0, 16 - i, 0, ac);
    @(negedge clk);
    check("empty_after_drain", 32'(empty), 32'd1);
    check("not_full_drain", 32'(full), 32'd0);
    @(posedge clk); #1;

    // 17 pushes: the last overflows, depth stays 16
    for (int i = 1; i <= 17; i++)
      do_cmd(1'b0, 8'(i), 8'h00, (i == 17), (i == 17) ? 16 : i, 0, ac);
    do_cmd(1'b1, 8'h00, 8'h10, 1'b0, 15, 0, ac);
    for (int i = 1; i <= 15; i++)
      do_cmd(1'b1, 8'h00, 8'(16 - i), 1'b0, 15 - i, 0, ac);

    // Underflow: data must read 0 even though the stack's data_out is stale
    do_cmd(1'b1, 8'h00, 8'h00, 1'b1, 0, 0, ac);

    // Backpressure for 10 cycles
    do_cmd(1'b0, 8'h3C, 8'h00, 1'b0, 1, 10, ac);

    // Reset during WAIT of a push
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b0;
    bus.cmd_data  = 8'h77;
    begin
      bit acc;
      acc = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.cmd_ready) begin @(posedge clk); acc = 1; break; end
      end
      if (!acc) check("accept_timeout_rst", 32'd0, 32'd1);
    end
    #1 bus.cmd_valid = 1'b0;
    inflight = 1;
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    model_stk.delete();
    model_depth = 0;
    inflight = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    $display("mid-op reset: rsp_valid=%0d cmd_ready=%0d empty=%0d",
             bus.rsp_valid, bus.cmd_ready, empty);
    check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_mid_empty", 32'(empty), 32'd1);
    @(posedge clk); #1;
    do_cmd(1'b1, 8'h00, 8'h00, 1'b1, 0, 0, ac);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
